// File: rtl/ospi_pkg.sv
// ospi_pkg: shared definitions for the octal-SPI initiator.
//   - host op encodings carried on cmd_op
//   - controller state enum (also exported on the debug state port)
//   - default flash opcodes
//   - small constant helper for sizing counters
package ospi_pkg;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_ER  = 2'd2;
  localparam logic [1:0] OP_ILL = 2'd3;

  localparam logic [7:0] DEF_OP_READ  = 8'h0B;
  localparam logic [7:0] DEF_OP_WRITE = 8'h02;
  localparam logic [7:0] DEF_OP_ERASE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_DESEL
  } ospi_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ospi_clk_phase.sv
// ospi_clk_phase: serial-clock phase generator.
// Each beat is two clk cycles: phase 0 (OSPI_CLK low) then phase 1
// (OSPI_CLK high). The phase only advances while en is high, i.e. while the
// controller is shifting beats; otherwise it parks low so the serial clock
// idles low (mode 0).
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset
//   en       in   beat shifting active (CS low, past SETUP)
//   sclk     out  registered serial clock
//   beat_end out  high in the CLK-high cycle, the last cycle of a beat
module ospi_clk_phase (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic beat_end
);

  logic phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
    end else if (en) begin
      phase <= ~phase;
    end else begin
      phase <= 1'b0;
    end
  end

  assign sclk     = phase;
  assign beat_end = en & phase;

endmodule

// File: rtl/ospi_master_ctrl.sv
// ospi_master_ctrl: octal-SPI initiator. Converts single-beat host requests
// (READ / WRITE / ERASE) into SDR octal transactions:
//   SETUP (1 cycle, CS low) -> CMD beat -> ADDR beats (MSB first)
//   -> {DUMMY beats + RDATA beat | WDATA beat | nothing} -> DESEL -> IDLE.
// Every beat is two clk cycles (CLK low, CLK high); IO_O/OE change only at
// the start of a beat. All pin outputs are registered.
// Ports:
//   clk, reset            system clock, async active-high reset
//   cmd_valid/cmd_ready   request handshake
//   cmd_op/addr/wdata     request fields, latched on acceptance
//   rd_data, rd_valid     read result and its one-cycle update pulse
//   cmd_err               one-cycle pulse after an illegal op is accepted
//   busy                  high while not IDLE
//   OSPI_CLK/CS/IO_O/IO_OE/IO_I  flash pins (tristate is at chip top)
//   dbg_state             current controller state, for observation only
//
// Handshake: a request transfers in the cycle where cmd_valid && cmd_ready
// are both high. cmd_ready is high exactly in IDLE and does not depend on
// cmd_valid; a requester holds cmd_valid and its fields stable until the
// transfer cycle, and the fields are don't-care afterwards.
module ospi_master_ctrl
  import ospi_pkg::*;
#(
  parameter int         WIDTH        = 8,
  parameter int         ADDR_BYTES   = 1,
  parameter int         DUMMY_CYCLES = 2,
  parameter int         CS_HIGH_MIN  = 2,   // must be >= 1
  parameter logic [7:0] OP_READ      = DEF_OP_READ,
  parameter logic [7:0] OP_WRITE     = DEF_OP_WRITE,
  parameter logic [7:0] OP_ERASE     = DEF_OP_ERASE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [WIDTH*ADDR_BYTES-1:0]   cmd_addr,
  input  logic [WIDTH-1:0]              cmd_wdata,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          rd_valid,
  output logic                          cmd_err,
  output logic                          busy,
  output logic                          OSPI_CLK,
  output logic                          OSPI_CS,
  output logic [WIDTH-1:0]              OSPI_IO_O,
  output logic                          OSPI_IO_OE,
  input  logic [WIDTH-1:0]              OSPI_IO_I,
  output ospi_state_t                   dbg_state
);

  localparam int ADDR_W = WIDTH * ADDR_BYTES;
  localparam int CNT_W  = $clog2(max_int(ADDR_BYTES, DUMMY_CYCLES) + 1);
  localparam int DSL_W  = $clog2(CS_HIGH_MIN + 1);

  ospi_state_t        state, state_n;
  logic [1:0]         op_q, op_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [WIDTH-1:0]   wdata_q, wdata_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;     // remaining ADDR / DUMMY beats
  logic [DSL_W-1:0]   dsl_q, dsl_n;     // remaining DESEL cycles
  logic [WIDTH-1:0]   io_q, io_n;
  logic               oe_q, oe_n;
  logic               cs_q, cs_n;
  logic [WIDTH-1:0]   rd_data_q, rd_data_n;
  logic               rd_valid_q, rd_valid_n;
  logic               cmd_err_q, cmd_err_n;
  logic               sclk_en;
  logic               beat_end;

  function automatic logic [WIDTH-1:0] opcode(input logic [1:0] op);
    case (op)
      OP_WR:   return WIDTH'(OP_WRITE);
      OP_ER:   return WIDTH'(OP_ERASE);
      default: return WIDTH'(OP_READ);
    endcase
  endfunction

  // Beats are shifted only in the states between SETUP and DESEL.
  assign sclk_en = (state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA});

  ospi_clk_phase u_clk_phase (
    .clk      (clk),
    .reset    (reset),
    .en       (sclk_en),
    .sclk     (OSPI_CLK),
    .beat_end (beat_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= OP_RD;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      dsl_q      <= '0;
      io_q       <= '0;
      oe_q       <= 1'b0;
      cs_q       <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state      <= state_n;
      op_q       <= op_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      cnt_q      <= cnt_n;
      dsl_q      <= dsl_n;
      io_q       <= io_n;
      oe_q       <= oe_n;
      cs_q       <= cs_n;
      rd_data_q  <= rd_data_n;
      rd_valid_q <= rd_valid_n;
      cmd_err_q  <= cmd_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    op_n       = op_q;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    cnt_n      = cnt_q;
    dsl_n      = dsl_q;
    io_n       = io_q;
    oe_n       = oe_q;
    cs_n       = cs_q;
    rd_data_n  = rd_data_q;
    rd_valid_n = 1'b0;
    cmd_err_n  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_ILL) begin
            // Accepted and flagged; no bus activity, stay ready.
            cmd_err_n = 1'b1;
          end else begin
            state_n = ST_SETUP;
            op_n    = cmd_op;
            addr_n  = cmd_addr;
            wdata_n = cmd_wdata;
            cs_n    = 1'b0;
          end
        end
      end

      ST_SETUP: begin
        state_n = ST_CMD;
        io_n    = opcode(op_q);
        oe_n    = 1'b1;
      end

      ST_CMD: begin
        if (beat_end) begin
          state_n = ST_ADDR;
          io_n    = addr_q[ADDR_W-1 -: WIDTH];
          oe_n    = 1'b1;
          addr_n  = addr_q << WIDTH;
          cnt_n   = CNT_W'(ADDR_BYTES - 1);
        end
      end

      ST_ADDR: begin
        if (beat_end) begin
          if (cnt_q != '0) begin
            io_n   = addr_q[ADDR_W-1 -: WIDTH];
            addr_n = addr_q << WIDTH;
            cnt_n  = cnt_q - 1'b1;
          end else if (op_q == OP_RD) begin
            // Turnaround: release the bus for dummy and read-data beats.
            io_n = '0;
            oe_n = 1'b0;
            if (DUMMY_CYCLES > 0) begin
              state_n = ST_DUMMY;
              cnt_n   = CNT_W'(DUMMY_CYCLES - 1);
            end else begin
              state_n = ST_RDATA;
            end
          end else if (op_q == OP_WR) begin
            state_n = ST_WDATA;
            io_n    = wdata_q;
            oe_n    = 1'b1;
          end else begin
            state_n = ST_DESEL;
            cs_n    = 1'b1;
            oe_n    = 1'b0;
            io_n    = '0;
            dsl_n   = DSL_W'(CS_HIGH_MIN - 1);
          end
        end
      end

      ST_DUMMY: begin
        if (beat_end) begin
          if (cnt_q != '0) begin
            cnt_n = cnt_q - 1'b1;
          end else begin
            state_n = ST_RDATA;
          end
        end
      end

      ST_RDATA: begin
        if (beat_end) begin
          // Sample at the end of the CLK-high cycle.
          rd_data_n  = OSPI_IO_I;
          rd_valid_n = 1'b1;
          state_n    = ST_DESEL;
          cs_n       = 1'b1;
          oe_n       = 1'b0;
          io_n       = '0;
          dsl_n      = DSL_W'(CS_HIGH_MIN - 1);
        end
      end

      ST_WDATA: begin
        if (beat_end) begin
          state_n = ST_DESEL;
          cs_n    = 1'b1;
          oe_n    = 1'b0;
          io_n    = '0;
          dsl_n   = DSL_W'(CS_HIGH_MIN - 1);
        end
      end

      ST_DESEL: begin
        if (dsl_q == '0) begin
          state_n = ST_IDLE;
        end else begin
          dsl_n = dsl_q - 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
        cs_n    = 1'b1;
        oe_n    = 1'b0;
        io_n    = '0;
      end
    endcase
  end

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign OSPI_CS    = cs_q;
  assign OSPI_IO_O  = io_q;
  assign OSPI_IO_OE = oe_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign cmd_err    = cmd_err_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_ospi_master_ctrl.sv
// Testbench for ospi_master_ctrl (default parameters).
// A pin-level flash model answers reads and applies writes/erases; a
// transaction-level reference memory predicts read data. Each transaction's
// pin timeline is predicted from the beat list and checked cycle by cycle.
module tb_ospi_master_ctrl;
  import ospi_pkg::*;

  localparam int W   = 8;
  localparam int AB  = 1;
  localparam int DC  = 2;
  localparam int CSH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [W*AB-1:0]   cmd_addr;
  logic [W-1:0]      cmd_wdata;
  logic [W-1:0]      rd_data;
  logic              rd_valid;
  logic              cmd_err;
  logic              busy;
  logic              OSPI_CLK;
  logic              OSPI_CS;
  logic [W-1:0]      OSPI_IO_O;
  logic              OSPI_IO_OE;
  logic [W-1:0]      io_i;
  ospi_state_t       dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] last_rd = 8'h00;

  always #5 clk = ~clk;

  ospi_master_ctrl #(
    .WIDTH(W), .ADDR_BYTES(AB), .DUMMY_CYCLES(DC), .CS_HIGH_MIN(CSH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .cmd_err    (cmd_err),
    .busy       (busy),
    .OSPI_CLK   (OSPI_CLK),
    .OSPI_CS    (OSPI_CS),
    .OSPI_IO_O  (OSPI_IO_O),
    .OSPI_IO_OE (OSPI_IO_OE),
    .OSPI_IO_I  (io_i),
    .dbg_state  (dbg_state)
  );

  // ---------------- memories ----------------
  logic [7:0] flash_mem [256];
  logic [7:0] ref_mem   [256];

  function automatic logic [7:0] init_val(input int i);
    if (i == 8'h3C) return 8'hA5;
    return 8'((i * 37 + 11) & 255);
  endfunction

  // ---------------- pin-level flash model ----------------
  // Beats are captured in their CLK-high cycle; read data is presented only
  // during the CLK-high cycle of the read-data beat (beat 4).
  int         fl_beat = 0;
  logic [7:0] fl_op   = 8'h00;
  logic [7:0] fl_addr = 8'h00;
  logic [7:0] fl_data = 8'h00;

  always @(negedge clk) begin
    if (OSPI_CS) begin
      if (fl_beat != 0) begin
        if (fl_op == 8'h02 && fl_beat == 3) flash_mem[fl_addr] = fl_data;
        if (fl_op == 8'h20 && fl_beat == 2)
          for (int i = 0; i < 16; i++) flash_mem[{fl_addr[7:4], 4'(i)}] = 8'hFF;
      end
      fl_beat = 0;
      io_i    = 8'h00;
    end else if (OSPI_CLK) begin
      case (fl_beat)
        0: fl_op   = OSPI_IO_O;
        1: fl_addr = OSPI_IO_O;
        2: fl_data = OSPI_IO_O;
        default: ;
      endcase
      if (fl_op == 8'h0B && fl_beat == 4) io_i = flash_mem[fl_addr];
      else io_i = ~flash_mem[fl_addr];
      fl_beat++;
    end else begin
      io_i = ~flash_mem[fl_addr];
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference-model memory update at transaction level.
  task automatic ref_apply(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata);
    if (op == OP_WR) ref_mem[addr] = wdata;
    if (op == OP_ER) for (int i = 0; i < 16; i++) ref_mem[{addr[7:4], 4'(i)}] = 8'hFF;
  endtask

  // Drive one request starting at a negedge, then check every cycle up to
  // and including the IDLE cycle after DESEL. Returns at a negedge.
  task automatic do_txn(input logic [1:0] op, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rd,
                        input bit hold, output int waited);
    logic [7:0] bval[$];
    bit         boe[$];
    bit         bchk[$];
    int         n;
    bit         is_rd;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    waited    = 0;
    while (!cmd_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: cmd_ready stayed %0b, required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom_range(0, 3));
    end
    cmd_addr  = 8'($urandom);
    cmd_wdata = 8'($urandom);

    if (op == OP_ILL) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        chk("ill_err",   cmd_err, (c == 1) ? 1 : 0);
        chk("ill_cs",    OSPI_CS, 1);
        chk("ill_busy",  busy, 0);
        chk("ill_ready", cmd_ready, 1);
      end
      return;
    end

    is_rd = (op == OP_RD);
    bval.push_back((op == OP_WR) ? 8'h02 : (op == OP_ER) ? 8'h20 : 8'h0B);
    boe.push_back(1); bchk.push_back(1);
    for (int a = AB - 1; a >= 0; a--) begin
      bval.push_back(8'(addr >> (8 * a))); boe.push_back(1); bchk.push_back(1);
    end
    if (is_rd) begin
      for (int d = 0; d < DC; d++) begin
        bval.push_back(8'h00); boe.push_back(0); bchk.push_back(1);
      end
      bval.push_back(8'h00); boe.push_back(0); bchk.push_back(0);
    end else if (op == OP_WR) begin
      bval.push_back(wdata); boe.push_back(1); bchk.push_back(1);
    end
    n = bval.size();

    for (int c = 1; c <= 2 * n + 2 + CSH; c++) begin
      @(negedge clk);
      if (c <= 2 * n + 1) begin
        chk("act_cs",     OSPI_CS, 0);
        chk("act_busy",   busy, 1);
        chk("act_ready",  cmd_ready, 0);
        chk("act_rdv",    rd_valid, 0);
        if (c == 1) begin
          chk("setup_clk", OSPI_CLK, 0);
          chk("setup_err", cmd_err, 0);
        end else begin
          chk("beat_clk", OSPI_CLK, (c - 2) % 2);
          chk("beat_oe",  OSPI_IO_OE, boe[(c - 2) / 2]);
          if (bchk[(c - 2) / 2]) chk("beat_io", OSPI_IO_O, bval[(c - 2) / 2]);
        end
      end else if (c == 2 * n + 2) begin
        chk("end_cs",     OSPI_CS, 1);
        chk("end_clk",    OSPI_CLK, 0);
        chk("end_oe",     OSPI_IO_OE, 0);
        chk("end_rdv",    rd_valid, is_rd ? 1 : 0);
        chk("end_rdata",  rd_data, is_rd ? exp_rd : last_rd);
        chk("end_ready",  cmd_ready, 0);
      end else if (c < 2 * n + 2 + CSH) begin
        chk("desel_cs",   OSPI_CS, 1);
        chk("desel_rdv",  rd_valid, 0);
        chk("desel_busy", busy, 1);
      end else begin
        chk("idle_ready", cmd_ready, 1);
        chk("idle_busy",  busy, 0);
        chk("idle_cs",    OSPI_CS, 1);
      end
    end
    if (is_rd) last_rd = exp_rd;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    logic [1:0] r_op;
    logic [7:0] r_addr, r_wdata;
    bit         r_hold;

    vecs[0] = '{OP_RD,  8'h3C, 8'h00, 8'hA5};
    vecs[1] = '{OP_WR,  8'h10, 8'h5A, 8'h00};
    vecs[2] = '{OP_RD,  8'h10, 8'h00, 8'h5A};
    vecs[3] = '{OP_ER,  8'h80, 8'h00, 8'h00};
    vecs[4] = '{OP_RD,  8'h80, 8'h00, 8'hFF};
    vecs[5] = '{OP_RD,  8'h85, 8'h00, 8'hFF};
    vecs[6] = '{OP_ILL, 8'h44, 8'h00, 8'h00};
    vecs[7] = '{OP_RD,  8'h3C, 8'h00, 8'hA5};

    for (int i = 0; i < 256; i++) begin
      flash_mem[i] = init_val(i);
      ref_mem[i]   = init_val(i);
    end

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    #2;
    chk("rst_cs",    OSPI_CS, 1);
    chk("rst_clk",   OSPI_CLK, 0);
    chk("rst_oe",    OSPI_IO_OE, 0);
    chk("rst_io",    OSPI_IO_O, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_rdv",   rd_valid, 0);
    chk("rst_err",   cmd_err, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0, waited);
      ref_apply(vecs[i].op, vecs[i].addr, vecs[i].wdata);
    end

    // Back-to-back reads with cmd_valid held high.
    do_txn(OP_RD, 8'h3C, 8'h00, ref_mem[8'h3C], 1'b1, waited);
    do_txn(OP_RD, 8'h10, 8'h00, ref_mem[8'h10], 1'b0, waited);
    chk("b2b_accept_wait", waited, 0);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      r_op    = 2'($urandom_range(0, 3));
      r_addr  = 8'($urandom);
      r_wdata = 8'($urandom);
      r_hold  = (r_op != OP_ILL) && ($urandom_range(0, 1) == 1);
      do_txn(r_op, r_addr, r_wdata, ref_mem[r_addr], r_hold, waited);
      ref_apply(r_op, r_addr, r_wdata);
    end
    cmd_valid = 1'b0;
    @(negedge clk);

    // Reset in the CLK-high cycle of the address beat of a read (T+5).
    cmd_op    = OP_RD;
    cmd_addr  = 8'h3C;
    cmd_valid = 1'b1;
    chk("mid_pre_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_pre_cs",  OSPI_CS, 0);
    chk("mid_pre_clk", OSPI_CLK, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_cs",   OSPI_CS, 1);
    chk("mid_rst_clk",  OSPI_CLK, 0);
    chk("mid_rst_oe",   OSPI_IO_OE, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset   = 1'b0;
    last_rd = 8'h00;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      chk("mid_post_rdv",   rd_valid, 0);
      chk("mid_post_ready", cmd_ready, 1);
      chk("mid_post_cs",    OSPI_CS, 1);
    end

    // Recovery read after the abandoned transaction.
    do_txn(OP_RD, 8'h3C, 8'h00, ref_mem[8'h3C], 1'b0, waited);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ospi_master_ctrl.md
Name: ospi_master_ctrl

Overview:
- Octal-SPI initiator: turns single-beat host requests (READ / WRITE / ERASE) into SDR octal transactions on OSPI_CLK / OSPI_CS / OSPI_IO.
- It is the host-side counterpart of ospi_flash. It sits between the system bus adapter and the flash pins.
- The pin-level tristate lives at the chip top; this block exposes split out / oe / in data.

Parameters:
- WIDTH, 8, OSPI data-bus width in bits (one beat = WIDTH bits).
- ADDR_BYTES, 1, number of address beats, sent MSB beat first; address width = WIDTH*ADDR_BYTES.
- DUMMY_CYCLES, 2, turnaround beats between address and read data.
- CS_HIGH_MIN, 2, minimum clk cycles OSPI_CS stays high between transactions.
- OP_READ, 8'h0B, read opcode.
- OP_WRITE, 8'h02, program opcode.
- OP_ERASE, 8'h20, sector-erase opcode.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  block can accept a request (high only in IDLE).
- cmd_op  in  2  0=READ, 1=WRITE, 2=ERASE, 3=illegal.
- cmd_addr  in  WIDTH*ADDR_BYTES  flash address.
- cmd_wdata  in  WIDTH  write data.
- rd_data  out  WIDTH  read result, held until the next read completes.
- rd_valid  out  1  one-cycle pulse when rd_data is updated.
- cmd_err  out  1  one-cycle pulse when an illegal op is accepted.
- busy  out  1  high from accept until return to IDLE.
- OSPI_CLK  out  1  serial clock, idle low (mode 0).
- OSPI_CS  out  1  chip select, active low.
- OSPI_IO_O  out  WIDTH  data driven toward flash.
- OSPI_IO_OE  out  1  drive enable for OSPI_IO_O.
- OSPI_IO_I  in  WIDTH  data sampled from flash.

Behaviour:
- Reset (async, any state), all values registered:
  - state=IDLE; OSPI_CS=1; OSPI_CLK=0; OSPI_IO_OE=0; OSPI_IO_O=0.
  - rd_data=0; rd_valid=0; cmd_err=0; busy=0.
  - cmd_ready=1 once reset deasserts.
  - A transaction in flight when reset hits is abandoned; CS rises immediately and no rd_valid is produced.
- Handshake:
  - Accept on cmd_valid&&cmd_ready in cycle T; op, addr and wdata are latched at T.
  - Inputs are don't-care after acceptance.
- Illegal op (3): accepted, cmd_err pulses at T+1, no bus activity, state stays IDLE, cmd_ready stays high.
- States: IDLE -> SETUP -> CMD -> ADDR -> {DUMMY -> RDATA | WDATA | none} -> DESEL -> IDLE.
- SETUP: exactly one cycle (T+1); CS=0, CLK=0.
- Beats:
  - Each beat is 2 clk cycles.
  - Beat k occupies T+2+2k (CLK=0, new IO_O/OE presented) and T+3+2k (CLK=1).
  - IO_O is stable across both cycles of the beat.
- Beat sequence:
  - CMD: opcode, OE=1.
  - ADDR: ADDR_BYTES beats, MSB byte first, OE=1.
  - WRITE: one WDATA beat, OE=1.
  - READ: DUMMY_CYCLES beats with OE=0, IO_O=0, then one RDATA beat with OE=0. OSPI_IO_I is sampled at the end of the RDATA CLK-high cycle.
  - ERASE: no data beat.
- Transaction end:
  - Cycle after the last beat's CLK-high cycle: CS=1, CLK=0, OE=0, enter DESEL.
  - For READ, rd_data is updated and rd_valid pulses in that same cycle.
- DESEL: lasts CS_HIGH_MIN cycles, then IDLE; cmd_ready rises the following cycle.
- Beat count N:
  - READ: 1 + ADDR_BYTES + DUMMY_CYCLES + 1.
  - WRITE: 1 + ADDR_BYTES + 1.
  - ERASE: 1 + ADDR_BYTES.
  - CS low spans 1 + 2N cycles.
- busy = (state != IDLE).
- cmd_valid while busy is ignored; the request is not lost, because ready stays low.
- DUMMY_CYCLES=0 is legal; RDATA follows ADDR directly.
- Beat counter width is clog2(max(ADDR_BYTES, DUMMY_CYCLES)+1).
- Address shift register shifts left by WIDTH per beat.

Decomposition:
- Shared package ospi_pkg holds:
  - op encodings: OP_RD=2'd0, OP_WR=2'd1, OP_ER=2'd2.
  - state enum.
  - default opcode constants.
- One sub-module, ospi_clk_phase: 1-bit phase toggler, enabled only while CS is low past SETUP. It produces OSPI_CLK and a beat_end strobe.
- Everything else (FSM, counters, shift register) lives in ospi_master_ctrl.

Test Plan:
All scenarios use defaults: WIDTH=8, ADDR_BYTES=1, DUMMY=2, CS_HIGH_MIN=2.
- Read: accept op=0, addr=8'h3C at T with flash model returning 8'hA5 -> IO_O=0B at T+2..3 and 3C at T+4..5; OE=0 from T+6; CS low T+1..T+11; rd_valid=1 with rd_data=A5 at T+12; cmd_ready=1 at T+14.
- Write: op=1, addr=8'h10, wdata=8'h5A -> beats 02,10,5A with OE=1 over T+2..T+7; CS high at T+8; no rd_valid; ready at T+10; read-back of 8'h10 returns 5A.
- Erase: op=2, addr=8'h80 -> beats 20,80; CS high at T+6; ready at T+8; subsequent read of 8'h80 returns FF.
- Back-to-back: cmd_valid held high with two reads -> second accept occurs exactly at first ready; CS stays high for ≥2 cycles between the transactions.
- Reset mid-transaction: assert reset at T+5 of a read -> CS=1, CLK=0, OE=0 in the same cycle (async); no rd_valid; cmd_ready=1 after release.
- Illegal op=3 -> cmd_err pulse at T+1, CS stays 1 throughout, busy stays 0.
